// File: rtl/rgb_stream_src.sv
// Turns the free-running HDMI pixel bus into a valid/ready pixel+meta stream.
// A FIFO absorbs stalls; an overflow drops pixels until the next frame start.
module rgb_stream_src #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     clr_i,
    input  logic                     pix_en_i,
    input  logic [7:0]               r_i,
    input  logic [7:0]               g_i,
    input  logic [7:0]               b_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     vde_i,
    output logic [7:0]               r_o,
    output logic [7:0]               g_o,
    output logic [7:0]               b_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     vde_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         frame_cnt_o,
    output logic [CNT_W-1:0]         ovf_cnt_o,
    output logic                     ovf_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = 27;

    typedef enum logic [1:0] {DISABLED, WAIT_SYNC, STREAM} state_e;

    state_e           state_q, state_d;
    logic             prev_vs_q, prev_vs_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             ovf_q, ovf_d;
    logic [WW-1:0]    mem_q [DEPTH];

    logic             fs, full, valid, pop, push_req, push, ovf_ev;
    logic [WW-1:0]    wdata, rdata;

    assign wdata    = {vsync_i, hsync_i, vde_i, r_i, g_i, b_i};
    assign fs       = pix_en_i & vsync_i & ~prev_vs_q;
    assign full     = (level_q == LW'(DEPTH));
    assign valid    = (level_q != '0);
    assign pop      = valid & ready_i;
    // Fullness is judged before any same-cycle pop, so a full FIFO always rejects.
    assign push_req = enable_i & pix_en_i &
                      ((state_q == STREAM) | ((state_q == WAIT_SYNC) & fs));
    assign push     = push_req & ~full;
    assign ovf_ev   = push_req & full;

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = DISABLED;
        end else begin
            case (state_q)
                DISABLED:  state_d = WAIT_SYNC;
                WAIT_SYNC: if (push) state_d = STREAM;
                STREAM:    if (ovf_ev) state_d = WAIT_SYNC;
                default:   state_d = DISABLED;
            endcase
        end

        prev_vs_d = pix_en_i ? vsync_i : prev_vs_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_d       = ovf_q;
        if (clr_i) begin
            frame_cnt_d = '0;
            ovf_cnt_d   = '0;
            ovf_d       = 1'b0;
        end else begin
            if (push && fs) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (ovf_ev) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= DISABLED;
            prev_vs_q   <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_vs_q   <= prev_vs_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = valid ? mem_q[rd_ptr_q] : '0;
    assign {vsync_o, hsync_o, vde_o, r_o, g_o, b_o} = rdata;

    assign valid_o     = valid;
    assign level_o     = level_q;
    assign frame_cnt_o = frame_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_rgb_stream_src.sv
// Bench for rgb_stream_src: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rgb_stream_src;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             enable_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             pix_en_i = 1'b0;
    logic [7:0]       r_i = '0, g_i = '0, b_i = '0;
    logic             hsync_i = 1'b0, vsync_i = 1'b0, vde_i = 1'b0;
    logic [7:0]       r_o, g_o, b_o;
    logic             hsync_o, vsync_o, vde_o, valid_o;
    logic             ready_i = 1'b1;
    logic [LW-1:0]    level_o;
    logic [CNT_W-1:0] frame_cnt_o, ovf_cnt_o;
    logic             ovf_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rgb_stream_src #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clr_i(clr_i),
        .pix_en_i(pix_en_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .vde_i(vde_i),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o),
        .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
        .frame_cnt_o(frame_cnt_o), .ovf_cnt_o(ovf_cnt_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stream is the list of accepted samples; capture is
    // either off, armed (waiting for a frame start) or locked onto a frame.
    logic [26:0]      mq[$];
    bit               m_armed = 0, m_locked = 0, m_prev_vs = 1, m_ovf = 0;
    int unsigned      m_fcnt = 0, m_ocnt = 0;

    always @(posedge clk_i) begin
        bit full, pop, fs, push, ovf;
        logic [26:0] exp_word;
        if (!rst_ni) begin
            mq.delete();
            m_armed = 0; m_locked = 0; m_prev_vs = 1;
            m_fcnt = 0; m_ocnt = 0; m_ovf = 0;
        end else begin
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && ready_i;
            fs   = pix_en_i && vsync_i && !m_prev_vs;
            push = 0; ovf = 0;
            if (!enable_i) begin
                m_armed = 0; m_locked = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (pix_en_i && (m_locked || fs)) begin
                if (full) begin ovf = 1; m_locked = 0; end
                else begin push = 1; m_locked = 1; end
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({vsync_i, hsync_i, vde_i, r_i, g_i, b_i});
            if (clr_i) begin
                m_fcnt = 0; m_ocnt = 0; m_ovf = 0;
            end else begin
                if (push && fs) m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
                if (ovf) begin
                    m_ovf = 1;
                    if (m_ocnt != (1 << CNT_W) - 1) m_ocnt++;
                end
            end
            if (pix_en_i) m_prev_vs = vsync_i;
        end
        #1;
        exp_word = (mq.size() != 0) ? mq[0] : 27'd0;
        check("valid", 32'(valid_o), 32'(mq.size() != 0));
        check("word", 32'({vsync_o, hsync_o, vde_o, r_o, g_o, b_o}), 32'(exp_word));
        check("level", 32'(level_o), 32'(mq.size()));
        check("frame_cnt", 32'(frame_cnt_o), m_fcnt);
        check("ovf_cnt", 32'(ovf_cnt_o), m_ocnt);
        check("ovf", 32'(ovf_o), 32'(m_ovf));
    end

    logic [7:0] pc = 8'd0;
    bit         duty2 = 0;
    bit         rnd_rdy = 0;

    task automatic drv(input logic pe, input logic vs, input logic hs, input logic de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk_i);
        pix_en_i = pe; vsync_i = vs; hsync_i = hs; vde_i = de;
        r_i = r; g_i = g; b_i = b;
        if (rnd_rdy) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pixel(input logic vs, input logic hs, input logic de);
        drv(1'b1, vs, hs, de, pc, pc ^ 8'h5a, pc + 8'd3);
        pc = pc + 8'd1;
        if (duty2)
            drv(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pixel(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int w, input int h);
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < w + 2; x++) pixel(1'b1, 1'b0, 1'b0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) pixel(1'b0, 1'b0, 1'b1);
            for (int x = 0; x < 2; x++) pixel(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and three full frames with ready held high
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_level", 32'(level_o), 0);
        rst_ni = 1'b1;
        enable_i = 1'b1;
        idle(3);
        for (int f = 0; f < 3; f++) frame(8, 4);
        idle(4);
        after_edge();
        check("t1_frames", 32'(frame_cnt_o), 3);
        check("t1_ovf_cnt", 32'(ovf_cnt_o), 0);

        // Reset taken while the input sits in vsync
        pixel(1'b1, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("t2_async_valid", 32'(valid_o), 0);
        check("t2_async_frames", 32'(frame_cnt_o), 0);
        pixel(1'b1, 1'b0, 1'b0);
        pixel(1'b1, 1'b0, 1'b0);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) pixel(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t2_no_push", 32'(level_o), 0);
        check("t2_no_fs", 32'(frame_cnt_o), 0);
        idle(4);
        pixel(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t2_first_valid", 32'(valid_o), 1);
        check("t2_first_vsync", 32'(vsync_o), 1);
        check("t2_fs_counted", 32'(frame_cnt_o), 1);
        frame(8, 4);

        // Overflow with ready held low
        enable_i = 1'b0;
        idle(3);
        ready_i = 1'b0;
        enable_i = 1'b1;
        idle(3);
        for (int i = 0; i < 9; i++) pixel(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t3_ovf", 32'(ovf_o), 1);
        check("t3_ovf_cnt", 32'(ovf_cnt_o), 1);
        check("t3_level_full", 32'(level_o), DEPTH);
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) pixel(1'b1, 1'b0, 1'b0);
        idle(4);
        after_edge();
        check("t3_drained", 32'(level_o), 0);
        pixel(1'b1, 1'b0, 1'b0);
        after_edge();
        check("t3_resync_vsync", 32'(vsync_o), 1);
        check("t3_resync_level", 32'(level_o), 1);
        idle(1);
        clr_i = 1'b1;
        after_edge();
        clr_i = 1'b0;
        check("t3_clr_ovf", 32'(ovf_o), 0);
        check("t3_clr_ovf_cnt", 32'(ovf_cnt_o), 0);
        check("t3_clr_frames", 32'(frame_cnt_o), 0);

        // Random ready, half-rate pixel strobe
        duty2 = 1;
        rnd_rdy = 1;
        frame(8, 4);
        frame(8, 4);
        duty2 = 0;
        rnd_rdy = 0;
        ready_i = 1'b1;
        idle(6);
        after_edge();
        check("t4_no_ovf", 32'(ovf_cnt_o), 0);
        check("t4_frames", 32'(frame_cnt_o), 2);

        // Enable dropped with five words queued
        enable_i = 1'b0;
        idle(3);
        ready_i = 1'b0;
        enable_i = 1'b1;
        idle(3);
        for (int i = 0; i < 5; i++) pixel(1'b1, 1'b0, 1'b0);
        after_edge();
        enable_i = 1'b0;
        check("t5_queued", 32'(level_o), 5);
        pixel(1'b1, 1'b0, 1'b0);
        idle(2);
        pixel(1'b1, 1'b0, 1'b0);
        ready_i = 1'b1;
        idle(8);
        after_edge();
        check("t5_drained", 32'(level_o), 0);
        check("t5_frames", 32'(frame_cnt_o), 3);
        enable_i = 1'b1;

        // Clear coinciding with a frame-start push
        ready_i = 1'b0;
        idle(4);
        pixel(1'b1, 1'b0, 1'b0);
        clr_i = 1'b1;
        after_edge();
        clr_i = 1'b0;
        check("t6_clr_frames", 32'(frame_cnt_o), 0);
        check("t6_clr_ovf", 32'(ovf_o), 0);
        check("t6_push_kept", 32'(level_o), 1);
        ready_i = 1'b1;
        idle(4);
        frame(8, 4);
        idle(4);
        after_edge();
        check("t6_frames", 32'(frame_cnt_o), 1);

        // Reset asserted mid-frame
        idle(2);
        for (int i = 0; i < 3; i++) pixel(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pixel(1'b0, 1'b0, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("t7_async_valid", 32'(valid_o), 0);
        check("t7_async_level", 32'(level_o), 0);
        check("t7_async_frames", 32'(frame_cnt_o), 0);
        check("t7_async_r", 32'(r_o), 0);
        pixel(1'b0, 1'b0, 1'b1);
        pixel(1'b0, 1'b0, 1'b1);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) pixel(1'b0, 1'b0, 1'b1);
        after_edge();
        check("t7_no_capture", 32'(level_o), 0);
        frame(8, 4);
        idle(4);
        after_edge();
        check("t7_frames", 32'(frame_cnt_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rgb_stream_src.md
# rgb_stream_src

Source stage feeding the RGB processing block: converts the free-running pixel bus from the HDMI receiver (one sample per `pix_en_i`, no back-pressure) into the valid/ready pixel+meta stream that the processing block consumes. An internal FIFO absorbs downstream stalls. Overflow drops pixels and then re-synchronises on the next frame start, so downstream frame FSMs never see a truncated frame start. Frame and overflow statistics are exported for the LED/status logic.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, ≥ 4.
- `CNT_W`, 16: width of the frame and overflow counters.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  capture enable; when low, input samples are discarded.
- `clr_i`  in  1  synchronous clear of counters and the sticky overflow flag.
- `pix_en_i`  in  1  input sample strobe; the pixel bus is valid only when high.
- `r_i`, `g_i`, `b_i`  in  8 each  input colour.
- `hsync_i`, `vsync_i`, `vde_i`  in  1 each  input timing meta.
- `r_o`, `g_o`, `b_o`  out  8 each  stream colour.
- `hsync_o`, `vsync_o`, `vde_o`  out  1 each  stream meta.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `frame_cnt_o`  out  CNT_W  frames started in STREAM; wraps.
- `ovf_cnt_o`  out  CNT_W  overflow events; saturates at all-ones.
- `ovf_o`  out  1  sticky: at least one overflow since reset or `clr_i`.

## Operation
- Sample word is 27 bits: {vsync, hsync, vde, r, g, b}.
- Frame start (FS): a cycle with `pix_en_i`=1, `vsync_i`=1 and the registered previous sampled vsync = 0.
  - The previous-vsync register updates only on `pix_en_i`.
  - It resets to 1, so a frame already in vsync at reset does not count as an FS.
- State machine states: DISABLED, WAIT_SYNC, STREAM. Reset state is DISABLED.
  - DISABLED → WAIT_SYNC when `enable_i`=1.
  - WAIT_SYNC → STREAM on an FS sample. That FS sample is pushed and counted.
  - STREAM → WAIT_SYNC on overflow.
  - Any state → DISABLED when `enable_i`=0. This takes priority over all other transitions.
- Push rules:
  - A push happens only in STREAM, or in WAIT_SYNC on the FS sample, and only when `pix_en_i`=1.
  - FIFO full is evaluated before any same-cycle pop. A sample that arrives while full is lost.
- Overflow: an attempted push while full.
  - `ovf_cnt_o` increments (saturating).
  - `ovf_o` sets.
  - State goes to WAIT_SYNC. The lost sample is not pushed.
- `frame_cnt_o` increments, with wrap, on every pushed FS sample.
- FIFO contents are never flushed by a state change. Already-accepted samples always drain.
- Output: `valid_o` = FIFO not empty. A pop happens on `valid_o && ready_i`.
- All data and meta outputs are forced to 0 while `valid_o`=0.
- `clr_i` zeroes both counters and `ovf_o`.
  - A same-cycle increment is lost; clear wins.
  - `clr_i` does not affect state or the FIFO.

## Timing
- Reset values:
  - `valid_o`=0; all data and meta outputs 0.
  - `level_o`=0, counters 0, `ovf_o`=0.
  - State is DISABLED.
- Latency: a sample pushed at edge t is visible with `valid_o`=1 in the cycle after t. There is no fall-through.
- Order is strictly preserved; there is no duplication.
- Output data is stable while `valid_o && !ready_i`. `valid_o` never drops without a pop.
- Simultaneous push and pop when not full: `level_o` is unchanged and both complete.
- At `level_o` = DEPTH-1, a push with no pop fills the FIFO. The next sample without a prior pop overflows.
- Pointers wrap modulo DEPTH. Occupancy distinguishes full from empty.
- Counter and flag updates are visible the cycle after the triggering edge.
- Reset asserted mid-frame: everything returns to its reset value immediately (asynchronously). Capture restarts only at the next FS after `enable_i`.

## Test plan
- Reset, then `enable_i`=1, `ready_i`=1, 3 frames of 8×4 active pixels with blanking and a vsync pulse:
  - `frame_cnt_o`=3, `ovf_cnt_o`=0.
  - The output sequence equals the input samples from the first FS onward, with 1-cycle latency.
- Start capture in mid-vsync at reset:
  - No FS is counted and nothing is pushed until the next vsync rising sample.
  - The first output word has vsync_o=1.
- `DEPTH`=8, `ready_i`=0, `pix_en_i` continuous:
  - The first 8 samples from FS are accepted; the 9th sets `ovf_o`, `ovf_cnt_o`=1, `level_o`=8.
  - Releasing `ready_i` drains exactly those 8 words.
  - The next output after that is the next FS sample.
- `ready_i` toggling randomly with `pix_en_i` at 1/2 duty:
  - No overflow occurs; output exactly equals input.
  - Data is held stable during stalls.
- `enable_i` dropped mid-frame with 5 words queued:
  - All 5 words drain, then there is no further output until re-enable plus FS.
- `clr_i` pulsed on the same cycle as an FS push:
  - Next cycle shows `frame_cnt_o`=0 and `ovf_o`=0; the push itself still happens (`level_o`+1).
